// File: rtl/logic_gate_unit.sv
`default_nettype none
// ============================================================================
// Module  : logic_gate_unit
// Brief   : Registered bitwise AND/OR/NOT/NOR/NAND/XOR/XNOR unit. Results are
//           computed by a gate-primitive network and by dataflow, then
//           cross-checked.
// Revision: 1.0 - initial release
// ============================================================================
module logic_gate_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_and,
    output logic [WIDTH-1:0] y_nand,
    output logic             mismatch
);

    localparam logic [2:0] c_OP_AND  = 3'd0;
    localparam logic [2:0] c_OP_OR   = 3'd1;
    localparam logic [2:0] c_OP_NOT  = 3'd2;
    localparam logic [2:0] c_OP_NOR  = 3'd3;
    localparam logic [2:0] c_OP_NAND = 3'd4;
    localparam logic [2:0] c_OP_XOR  = 3'd5;
    localparam logic [2:0] c_OP_XNOR = 3'd6;

    logic [WIDTH-1:0] w_g_and, w_g_or, w_g_not, w_g_nor, w_g_nand, w_g_xor, w_g_xnor;
    logic [WIDTH-1:0] w_d_and, w_d_or, w_d_not, w_d_nor, w_d_nand, w_d_xor, w_d_xnor;
    logic [WIDTH-1:0] w_g_sel, w_d_sel;
    logic             w_mismatch;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_y, r_y_and, r_y_nand;
    logic             r_mismatch;

    // Structural path: one primitive per bit per function
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            and  u_and  (w_g_and[i],  a[i], b[i]);
            or   u_or   (w_g_or[i],   a[i], b[i]);
            not  u_not  (w_g_not[i],  a[i]);
            nor  u_nor  (w_g_nor[i],  a[i], b[i]);
            nand u_nand (w_g_nand[i], a[i], b[i]);
            xor  u_xor  (w_g_xor[i],  a[i], b[i]);
            xnor u_xnor (w_g_xnor[i], a[i], b[i]);
        end
    endgenerate

    assign w_d_and  = a & b;
    assign w_d_or   = a | b;
    assign w_d_not  = ~a;
    assign w_d_nor  = ~(a | b);
    assign w_d_nand = ~(a & b);
    assign w_d_xor  = a ^ b;
    assign w_d_xnor = ~(a ^ b);

    always_comb begin
        w_g_sel = '0;
        w_d_sel = '0;
        case (op)
            c_OP_AND:  begin w_g_sel = w_g_and;  w_d_sel = w_d_and;  end
            c_OP_OR:   begin w_g_sel = w_g_or;   w_d_sel = w_d_or;   end
            c_OP_NOT:  begin w_g_sel = w_g_not;  w_d_sel = w_d_not;  end
            c_OP_NOR:  begin w_g_sel = w_g_nor;  w_d_sel = w_d_nor;  end
            c_OP_NAND: begin w_g_sel = w_g_nand; w_d_sel = w_d_nand; end
            c_OP_XOR:  begin w_g_sel = w_g_xor;  w_d_sel = w_d_xor;  end
            c_OP_XNOR: begin w_g_sel = w_g_xnor; w_d_sel = w_d_xnor; end
            default:   begin w_g_sel = '0;       w_d_sel = '0;       end
        endcase
    end

    assign w_mismatch = |(w_g_sel ^ w_d_sel);

    // Results hold while idle; only the strobe and mismatch drop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_mismatch  <= 1'b0;
            r_y         <= '0;
            r_y_and     <= '0;
            r_y_nand    <= '0;
        end else begin
            r_out_valid <= in_valid;
            r_mismatch  <= in_valid & w_mismatch;
            if (in_valid) begin
                r_y      <= w_d_sel;
                r_y_and  <= w_d_and;
                r_y_nand <= w_d_nand;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign y_and     = r_y_and;
    assign y_nand    = r_y_nand;
    assign mismatch  = r_mismatch;

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_logic_gate_unit
// Brief   : Directed and random self-checking bench for logic_gate_unit at
//           WIDTH=1 and WIDTH=4.
// Revision: 1.0 - initial release
// ============================================================================
module tb_logic_gate_unit;

    logic       clk = 1'b0;
    logic       rst;
    always #5 clk = ~clk;

    // WIDTH=1 instance
    logic       iv1;
    logic [0:0] a1, b1;
    logic [2:0] op1;
    logic       ov1, mm1;
    logic [0:0] y1, ya1, yn1;

    // WIDTH=4 instance
    logic       iv4;
    logic [3:0] a4, b4;
    logic [2:0] op4;
    logic       ov4, mm4;
    logic [3:0] y4, ya4, yn4;

    logic_gate_unit #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .op(op1),
        .out_valid(ov1), .y(y1), .y_and(ya1), .y_nand(yn1), .mismatch(mm1)
    );

    logic_gate_unit #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .a(a4), .b(b4), .op(op4),
        .out_valid(ov4), .y(y4), .y_and(ya4), .y_nand(yn4), .mismatch(mm4)
    );

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
        logic [3:0] y_and;
        logic [3:0] y_nand;
    } vec_t;

    vec_t       vecs4 [8];
    logic [0:3] tt1 [7];   // truth table per op, indexed by {a,b}

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ref_y(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        case (op)
            3'd0: ref_y = a & b;
            3'd1: ref_y = a | b;
            3'd2: ref_y = ~a;
            3'd3: ref_y = ~(a | b);
            3'd4: ref_y = ~(a & b);
            3'd5: ref_y = a ^ b;
            3'd6: ref_y = ~(a ^ b);
            default: ref_y = 4'b0000;
        endcase
    endfunction

    initial begin
        logic [3:0] e_y, e_ya, e_yn;
        logic       e_v;
        logic [1:0] idx;

        tt1[0] = 4'b0001; // AND
        tt1[1] = 4'b0111; // OR
        tt1[2] = 4'b1100; // NOT
        tt1[3] = 4'b1000; // NOR
        tt1[4] = 4'b1110; // NAND
        tt1[5] = 4'b0110; // XOR
        tt1[6] = 4'b1001; // XNOR

        vecs4[0] = '{3'd0, 4'b1100, 4'b1010, 4'b1000, 4'b1000, 4'b0111};
        vecs4[1] = '{3'd1, 4'b1100, 4'b1010, 4'b1110, 4'b1000, 4'b0111};
        vecs4[2] = '{3'd2, 4'b1100, 4'b1010, 4'b0011, 4'b1000, 4'b0111};
        vecs4[3] = '{3'd3, 4'b1100, 4'b1010, 4'b0001, 4'b1000, 4'b0111};
        vecs4[4] = '{3'd4, 4'b1100, 4'b1010, 4'b0111, 4'b1000, 4'b0111};
        vecs4[5] = '{3'd5, 4'b1100, 4'b1010, 4'b0110, 4'b1000, 4'b0111};
        vecs4[6] = '{3'd6, 4'b1100, 4'b1010, 4'b1001, 4'b1000, 4'b0111};
        vecs4[7] = '{3'd7, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111};

        // Reset with a simultaneous transaction on both instances
        rst = 1'b1;
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; op1 = 3'd0;
        iv4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111; op4 = 3'd0;
        tick();
        tick();
        n_vec++;
        chk("rst_ov4", {3'b0, ov4}, 4'b0000);
        chk("rst_y4", y4, 4'b0000);
        chk("rst_ya4", ya4, 4'b0000);
        chk("rst_yn4", yn4, 4'b0000);
        chk("rst_mm4", {3'b0, mm4}, 4'b0000);
        chk("rst_ov1", {3'b0, ov1}, 4'b0000);
        chk("rst_y1", {3'b0, y1}, 4'b0000);
        chk("rst_yn1", {3'b0, yn1}, 4'b0000);

        rst = 1'b0;
        iv1 = 1'b0;
        tick();
        n_vec++;
        chk("post_rst_ov", {3'b0, ov4}, 4'b0001);
        chk("post_rst_y", y4, 4'b1111);
        chk("post_rst_mm", {3'b0, mm4}, 4'b0000);

        // Reset mid-stream discards the in-flight transaction
        a4 = 4'b0101; b4 = 4'b0011; op4 = 3'd5;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        iv4 = 1'b0;
        n_vec++;
        chk("midrst_ov", {3'b0, ov4}, 4'b0000);
        chk("midrst_y", y4, 4'b0000);
        chk("midrst_yn", yn4, 4'b0000);

        // WIDTH=1 exhaustive, back-to-back
        iv1 = 1'b1;
        for (int op = 0; op < 7; op++) begin
            for (int ab = 0; ab < 4; ab++) begin
                idx = ab[1:0];
                op1 = op[2:0];
                a1  = idx[1];
                b1  = idx[0];
                tick();
                n_vec++;
                chk($sformatf("w1_ov_op%0d_ab%0d", op, ab), {3'b0, ov1}, 4'b0001);
                chk($sformatf("w1_y_op%0d_ab%0d", op, ab), {3'b0, y1}, {3'b0, tt1[op][idx]});
                chk($sformatf("w1_ya_op%0d_ab%0d", op, ab), {3'b0, ya1}, {3'b0, tt1[0][idx]});
                chk($sformatf("w1_yn_op%0d_ab%0d", op, ab), {3'b0, yn1}, {3'b0, tt1[4][idx]});
                chk($sformatf("w1_mm_op%0d_ab%0d", op, ab), {3'b0, mm1}, 4'b0000);
            end
        end
        iv1 = 1'b0;

        // WIDTH=4 table, back-to-back including reserved op
        iv4 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op4 = vecs4[i].op;
            a4  = vecs4[i].a;
            b4  = vecs4[i].b;
            tick();
            n_vec++;
            chk($sformatf("w4_ov_%0d", i), {3'b0, ov4}, 4'b0001);
            chk($sformatf("w4_y_%0d", i), y4, vecs4[i].y);
            chk($sformatf("w4_ya_%0d", i), ya4, vecs4[i].y_and);
            chk($sformatf("w4_yn_%0d", i), yn4, vecs4[i].y_nand);
            chk($sformatf("w4_mm_%0d", i), {3'b0, mm4}, 4'b0000);
        end

        // Hold: accept one NAND, then idle three cycles with changing inputs
        a4 = 4'b0110; b4 = 4'b0011; op4 = 3'd4;
        tick();
        n_vec++;
        chk("hold_acc_y", y4, 4'b1101);
        iv4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a4 = 4'(i + 9); b4 = 4'(i * 5); op4 = 3'(i);
            tick();
            n_vec++;
            chk($sformatf("hold_y_%0d", i), y4, 4'b1101);
            chk($sformatf("hold_ya_%0d", i), ya4, 4'b0010);
            chk($sformatf("hold_yn_%0d", i), yn4, 4'b1101);
            chk($sformatf("hold_ov_%0d", i), {3'b0, ov4}, 4'b0000);
            chk($sformatf("hold_mm_%0d", i), {3'b0, mm4}, 4'b0000);
        end

        // Random with scoreboard of held results
        e_y = 4'b1101; e_ya = 4'b0010; e_yn = 4'b1101;
        for (int i = 0; i < 100; i++) begin
            iv4 = 1'($urandom_range(0, 1));
            a4  = 4'($urandom);
            b4  = 4'($urandom);
            op4 = 3'($urandom);
            e_v = iv4;
            if (iv4) begin
                e_y  = ref_y(a4, b4, op4);
                e_ya = a4 & b4;
                e_yn = ~(a4 & b4);
            end
            tick();
            n_vec++;
            chk($sformatf("rnd_ov_%0d", i), {3'b0, ov4}, {3'b0, e_v});
            chk($sformatf("rnd_y_%0d", i), y4, e_y);
            chk($sformatf("rnd_ya_%0d", i), ya4, e_ya);
            chk($sformatf("rnd_yn_%0d", i), yn4, e_yn);
            chk($sformatf("rnd_mm_%0d", i), {3'b0, mm4}, 4'b0000);
        end
        iv4 = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
